// File: rtl/rv_fifo_ndeep.sv
// Parametrised ready/valid FIFO with occupancy count and almost-full flag.
// Define RV_FIFO_BYPASS_EN for zero-latency fall-through when empty.
module rv_fifo_ndeep #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned   CW        = $clog2(DEPTH + 1);
  localparam int unsigned   PW        = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          empty;

  // Flow-control flags depend on registered occupancy only.
  assign empty       = (count == '0);
  assign in_ready    = (count != CNT_FULL);
  assign almost_full = (count >= CNT_AFULL);

`ifdef RV_FIFO_BYPASS_EN
  logic bypass;

  // When empty, a word the consumer takes immediately never touches storage.
  assign bypass    = empty & in_valid & out_ready;
  assign out_valid = empty ? in_valid : 1'b1;
  assign out_data  = empty ? in_data : mem[rd_ptr];
  assign push      = in_valid & in_ready & ~bypass;
  assign pop       = out_valid & out_ready & ~empty;
`else
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
`endif

  // Storage array: contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap by explicit compare so any DEPTH works.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_fifo_ndeep.sv
// Bench for rv_fifo_ndeep: a 4-deep and a 3-deep instance share one stimulus
// stream; per-instance scoreboards check every cycle, directed checks cover the plan.
module tb_rv_fifo_ndeep;

`ifdef RV_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        in_ready4, out_valid4, afull4;
  logic [31:0] out_data4;
  logic [2:0]  count4;
  logic        in_ready3, out_valid3, afull3;
  logic [31:0] out_data3;
  logic [1:0]  count3;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  rv_fifo_ndeep #(.DW(32), .DEPTH(4), .AFULL_TH(3)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .count(count4), .almost_full(afull4));

  rv_fifo_ndeep #(.DW(32), .DEPTH(3), .AFULL_TH(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .count(count3), .almost_full(afull3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 4-deep instance: model state reflects the next edge.
  int          mc4 = 0;
  logic [31:0] q4[$];
  bit          st4 = 1'b0;
  logic [31:0] st4_d;
  always @(negedge clk) begin : mon4
    logic ov, p, pp;
    logic [31:0] ed;
    if (mon_en) begin
      ov = (mc4 != 0) || (BYP && in_valid);
      chk("in_ready4", 32'(in_ready4), 32'(mc4 != 4));
      chk("out_valid4", 32'(out_valid4), 32'(ov));
      chk("count4", 32'(count4), 32'(mc4));
      chk("afull4", 32'(afull4), 32'(mc4 >= 3));
      if (st4) begin
        chk("stall_valid4", 32'(out_valid4), 32'd1);
        chk("stall_data4", out_data4, st4_d);
      end
      ed = (mc4 == 0) ? in_data : q4[0];
      if (ov && out_ready) chk("pop_data4", out_data4, ed);
      st4 = !rst && (mc4 != 0) && !out_ready;
      st4_d = out_data4;
      if (rst) begin
        mc4 = 0;
        q4.delete();
      end else begin
        p  = in_valid && (mc4 != 4);
        pp = ov && out_ready;
        if (!(mc4 == 0 && p && pp)) begin
          if (p) begin q4.push_back(in_data); mc4++; end
          if (pp) begin void'(q4.pop_front()); mc4--; end
        end
      end
    end
  end

  // Scoreboard for the 3-deep instance (non-power-of-two wrap).
  int          mc3 = 0;
  logic [31:0] q3[$];
  bit          st3 = 1'b0;
  logic [31:0] st3_d;
  always @(negedge clk) begin : mon3
    logic ov, p, pp;
    logic [31:0] ed;
    if (mon_en) begin
      ov = (mc3 != 0) || (BYP && in_valid);
      chk("in_ready3", 32'(in_ready3), 32'(mc3 != 3));
      chk("out_valid3", 32'(out_valid3), 32'(ov));
      chk("count3", 32'(count3), 32'(mc3));
      chk("afull3", 32'(afull3), 32'(mc3 >= 2));
      if (st3) begin
        chk("stall_valid3", 32'(out_valid3), 32'd1);
        chk("stall_data3", out_data3, st3_d);
      end
      ed = (mc3 == 0) ? in_data : q3[0];
      if (ov && out_ready) chk("pop_data3", out_data3, ed);
      st3 = !rst && (mc3 != 0) && !out_ready;
      st3_d = out_data3;
      if (rst) begin
        mc3 = 0;
        q3.delete();
      end else begin
        p  = in_valid && (mc3 != 3);
        pp = ov && out_ready;
        if (!(mc3 == 0 && p && pp)) begin
          if (p) begin q3.push_back(in_data); mc3++; end
          if (pp) begin void'(q3.pop_front()); mc3--; end
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_count", 32'(count4), 32'd0);
    chk("reset_in_ready", 32'(in_ready4), 32'd1);
    chk("reset_out_valid", 32'(out_valid4), 32'd0);
    chk("reset_afull", 32'(afull4), 32'd0);

    // Fill with consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      step();
      chk("fill_count", 32'(count4), 32'(i + 1));
      chk("fill_afull", 32'(afull4), 32'((i + 1) >= 3));
      chk("fill_in_ready", 32'(in_ready4), 32'((i + 1) != 4));
    end
    chk("fill_count3", 32'(count3), 32'd3);
    in_data = 32'h4;
    step();
    chk("fifth_rejected", 32'(count4), 32'd4);
    in_valid = 1'b0;

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", out_data4, 32'(i));
      step();
    end
    chk("drain_out_valid", 32'(out_valid4), 32'd0);
    chk("drain_count", 32'(count4), 32'd0);
    chk("drain_in_ready", 32'(in_ready4), 32'd1);

    // Streaming with wrap-around.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h10 + 32'(i);
      step();
      chk("stream_count4", 32'(count4), BYP ? 32'd0 : 32'd1);
      chk("stream_count3", 32'(count3), BYP ? 32'd0 : 32'd1);
      if (!BYP) chk("stream_head", out_data4, 32'h10 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_count", 32'(count4), 32'd0);

    // Random traffic with backpressure, then drain.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = $urandom_range(0, 1) == 1;
      in_data   = $urandom;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    chk("rand_end_count4", 32'(count4), 32'd0);
    chk("rand_end_count3", 32'(count3), 32'd0);

    // Reset mid-operation.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_reset_count", 32'(count4), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_reset_count", 32'(count4), 32'd0);
    chk("mid_reset_out_valid", 32'(out_valid4), 32'd0);
    chk("mid_reset_in_ready", 32'(in_ready4), 32'd1);
    in_valid = 1'b1;
    in_data  = 32'hA5A5A5A5;
    step();
    in_valid = 1'b0;
    chk("post_reset_valid", 32'(out_valid4), 32'd1);
    chk("post_reset_data", out_data4, 32'hA5A5A5A5);
    out_ready = 1'b1;
    step();
    chk("post_reset_drained", 32'(count4), 32'd0);

`ifdef RV_FIFO_BYPASS_EN
    // Fall-through when empty, then a stalled word that gets stored.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hDEADBEEF;
    #1;
    chk("bypass_valid", 32'(out_valid4), 32'd1);
    chk("bypass_data", out_data4, 32'hDEADBEEF);
    step();
    chk("bypass_count", 32'(count4), 32'd0);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("bypass_stall_count", 32'(count4), 32'd1);
    chk("bypass_stall_data", out_data4, 32'hDEADBEEF);
    out_ready = 1'b1;
    step();
    chk("bypass_stall_drained", 32'(count4), 32'd0);
`endif

    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_fifo_ndeep.md
# rv_fifo_ndeep

Parametrised ready/valid FIFO with configurable data width and depth, for the elastic-buffer stages in the streaming datapath. It decouples a producer and consumer that both use the valid/ready handshake. It also provides an occupancy count and an almost-full flag for upstream flow control. With the default build it is a drop-in deeper replacement for the single-entry register slice.

## Interface
- `DW`, 32, payload width in bits (≥1)
- `DEPTH`, 4, number of storage entries (≥2; any integer, need not be a power of two)
- `AFULL_TH`, `DEPTH-1`, `almost_full` asserts when `count ≥ AFULL_TH` (1..`DEPTH`)

Ports:
- `clk`  input  1  single clock; all logic on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `in_valid`  input  1  producer offers `in_data`
- `in_ready`  output  1  FIFO can accept this cycle
- `in_data`  input  `DW`  write payload
- `out_valid`  output  1  `out_data` holds valid head entry
- `out_ready`  input  1  consumer accepts this cycle
- `out_data`  output  `DW`  head payload
- `count`  output  `$clog2(DEPTH+1)`  current occupancy, 0..`DEPTH`
- `almost_full`  output  1  `count ≥ AFULL_TH`

## Operation
- `push = in_valid & in_ready`; `pop = out_valid & out_ready`.
- Storage is a circular array `mem[DEPTH]` with write pointer `wr_ptr` and read pointer `rd_ptr`. Each pointer wraps from `DEPTH-1` to 0 by explicit compare, not by modulo 2^n.
- Push: `mem[wr_ptr] <= in_data`, `wr_ptr` advances.
- Pop: `rd_ptr` advances.
- `count` is +1 on push only, −1 on pop only, and unchanged on both or neither.
- `in_ready = (count != DEPTH)`. It never depends on `out_ready`, so there is no combinational ready path through the FIFO.
- `out_valid = (count != 0)`; `out_data = mem[rd_ptr]`, a combinational read of the registered array.
- Simultaneous push and pop at `0 < count < DEPTH`: both pointers advance and `count` holds.
- At `count == DEPTH`, push is impossible because `in_ready` is 0. At `count == 0`, pop is impossible because `out_valid` is 0 (default build).
- Stall guarantee: while `out_valid & !out_ready`, `out_valid` stays 1 and `out_data` is unchanged next cycle. A concurrent push writes `wr_ptr`, which is never equal to `rd_ptr` when `0 < count < DEPTH`.
- Order is strict FIFO; no entry is dropped or duplicated.
- Reset (synchronous, also mid-operation): `wr_ptr = rd_ptr = 0`, `count = 0`. Stored data is discarded and not cleared (`mem` contents are don't-care).

## Timing
- Reset values: `in_ready = 1`, `out_valid = 0`, `count = 0`, `almost_full = 0` (with `AFULL_TH ≥ 1`). `out_data` is undefined while `out_valid = 0`.
- `in_ready` is 0 during the reset cycle(s) only if `rst` is asserted combinationally at the output. Otherwise it is valid from the first cycle after `rst` deasserts.
- Latency in the default build: a push at edge N makes `out_valid = 1` from edge N onward (visible in cycle N+1). Minimum push-to-pop latency is 1 cycle.
- `count`, `almost_full`, `in_ready` and `out_valid` are all functions of registered state only.
- Throughput: 1 transfer/cycle sustained when both sides are always valid/ready.

## Configuration
- `RV_FIFO_BYPASS_EN` **not defined** (default): behaviour exactly as above, with 1-cycle minimum latency.
- `RV_FIFO_BYPASS_EN` **defined**: zero-latency fall-through when empty.
  - When `count == 0`: `out_valid = in_valid` and `out_data = in_data`.
  - If `in_valid & out_ready` while empty, the word passes straight through. Nothing is written to `mem`, and pointers and `count` stay unchanged.
  - If `in_valid & !out_ready` while empty, the word is written normally (`count` becomes 1). The stall guarantee then holds from the next cycle.
  - `in_ready` is unchanged, so it still has no `out_ready` dependency.
  - This build adds a combinational path from `in_valid`/`in_data` to `out_valid`/`out_data`.

## Test plan
Each scenario runs with `DW = 32`, `DEPTH = 4`, `AFULL_TH = 3` unless stated.

- **Fill:** hold `out_ready = 0` and push 0x0..0x3.
  - `count` goes 1, 2, 3, 4; `almost_full` rises at `count = 3`; `in_ready = 0` at `count = 4`.
  - A 5th `in_valid` is not accepted.
- **Drain:** from full, `out_ready = 1` for 4 cycles. The consumer sees 0x0, 0x1, 0x2, 0x3 in order, then `out_valid = 0`, `count = 0`, `in_ready = 1`.
- **Streaming with wrap-around:** `in_valid = out_ready = 1` for 10 cycles with payloads 0x10..0x19.
  - The consumer receives 0x10..0x19 in order and `count` never exceeds 1.
  - Repeat with `DEPTH = 3` to exercise the non-power-of-two wrap.
- **Stall and random backpressure:**
  - Random `out_ready` (50%) and `in_valid` (70%) for 300 cycles, then drain with `out_ready = 1` for 20 cycles.
  - A scoreboard matches every pop in order; `count` ends at 0.
  - Assertions: `out_data` and `out_valid` stable during `out_valid & !out_ready`; `count` never exceeds 4.
- **Reset mid-operation:** with `count = 3`, assert `rst` for 1 cycle.
  - Next cycle `count = 0`, `out_valid = 0`, `in_ready = 1`.
  - A subsequent push of 0xA5A5A5A5 is the next word popped.
- **Bypass (`RV_FIFO_BYPASS_EN` defined):**
  - Empty FIFO, `in_valid = out_ready = 1`, `in_data = 0xDEADBEEF`: `out_valid = 1` and `out_data = 0xDEADBEEF` in the same cycle, with `count` staying 0.
  - With `out_ready = 0` instead: `count = 1`, and the word is popped on a later cycle.
